// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS trace monitor: FSM states and trace-entry layout.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Entry layout, LSB first: jump, branch, instruction, pc.
    localparam int JUMP_BIT   = 0;
    localparam int BRANCH_BIT = 1;
    localparam int INSTR_LSB  = 2;

    function automatic int pc_lsb(input int instr_w);
        return instr_w + 2;
    endfunction

    function automatic int entry_w(input int pc_w, input int instr_w);
        return pc_w + instr_w + 2;
    endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Trace FIFO: registered storage, no fall-through, drops the incoming entry when full
// unless a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    assign valid_o = !empty;
    assign data_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mips_trace_monitor.sv
// Trace monitor for a MIPS core: captures pc changes into a FIFO, halts on a
// breakpoint address, and keeps saturating run statistics.
module mips_trace_monitor
    import mips_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PC_W-1:0]           pc,
    input  logic [INSTR_W-1:0]        instrucao,
    input  logic                      branch,
    input  logic                      jump,
    input  logic                      bp_en,
    input  logic [PC_W-1:0]           bp_pc,
    input  logic                      resume,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W+INSTR_W+1:0]   out_data,
    output logic                      halt,
    output logic                      overflow,
    output logic [CNT_W-1:0]          cycles,
    output logic [CNT_W-1:0]          retired,
    output logic [CNT_W-1:0]          branches,
    output logic [CNT_W-1:0]          jumps
);
    localparam int ENTRY_W = entry_w(PC_W, INSTR_W);
    localparam int PC_LSB  = pc_lsb(INSTR_W);

    state_t               state_q;
    logic                 halt_q;
    logic                 first_q;
    logic                 overflow_q;
    logic [PC_W-1:0]      prev_pc_q;
    logic [CNT_W-1:0]     cycles_q, retired_q, branches_q, jumps_q;
    logic [CNT_W-1:0]     cycles_d, retired_d, branches_d, jumps_d;
    logic [ENTRY_W-1:0]   entry_d;
    logic                 evt;
    logic                 hit;
    logic                 drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // first_q makes the first RUN cycle after IDLE an event even if pc is unchanged.
    assign evt = (state_q == ST_RUN) && (first_q || (pc != prev_pc_q));
    assign hit = evt && bp_en && (pc == bp_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    first_q <= 1'b1;
                    if (enable) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    first_q <= 1'b0;
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (hit) begin
                        state_q <= ST_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        halt_q  <= 1'b0;
                    end else if (resume) begin
                        state_q <= ST_RUN;
                        halt_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        prev_pc_q <= pc;
    end

    always_comb begin
        cycles_d   = sat_inc(cycles_q, state_q == ST_RUN);
        retired_d  = sat_inc(retired_q, evt);
        branches_d = sat_inc(branches_q, evt && branch);
        jumps_d    = sat_inc(jumps_q, evt && jump);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q   <= '0;
            retired_q  <= '0;
            branches_q <= '0;
            jumps_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycles_q   <= cycles_d;
            retired_q  <= retired_d;
            branches_q <= branches_d;
            jumps_q    <= jumps_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        entry_d                         = '0;
        entry_d[JUMP_BIT]               = jump;
        entry_d[BRANCH_BIT]             = branch;
        entry_d[INSTR_LSB +: INSTR_W]   = instrucao;
        entry_d[PC_LSB +: PC_W]         = pc;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (evt),
        .data_i  (entry_d),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .drop_o  (drop)
    );

    assign halt     = halt_q;
    assign overflow = overflow_q;
    assign cycles   = cycles_q;
    assign retired  = retired_q;
    assign branches = branches_q;
    assign jumps    = jumps_q;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Scoreboard bench for mips_trace_monitor: a DEPTH=4 instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation case.
module tb_mips_trace_monitor;

    logic        clk = 1'b0;
    logic        reset, enable, branch, jump, bp_en, resume, out_ready;
    logic [31:0] pc, instrucao, bp_pc;

    logic        out_valid, halt, overflow;
    logic [65:0] out_data;
    logic [31:0] cycles, retired, branches, jumps;

    logic        v1, h1, o1;
    logic [65:0] d1;
    logic [1:0]  c1, r1, b1, j1;

    logic [65:0] exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    mips_trace_monitor #(.DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .pc(pc), .instrucao(instrucao),
        .branch(branch), .jump(jump), .bp_en(bp_en), .bp_pc(bp_pc), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .halt(halt), .overflow(overflow), .cycles(cycles), .retired(retired),
        .branches(branches), .jumps(jumps)
    );

    mips_trace_monitor #(.DEPTH(4), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .pc(pc), .instrucao(instrucao),
        .branch(branch), .jump(jump), .bp_en(bp_en), .bp_pc(bp_pc), .resume(resume),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .halt(h1), .overflow(o1), .cycles(c1), .retired(r1),
        .branches(b1), .jumps(j1)
    );

    // One clock of stimulus; ev says whether this cycle must produce a trace entry.
    task automatic drive(input logic en, input logic [31:0] p, input logic br,
                         input logic jp, input bit ev);
        enable    = en;
        pc        = p;
        instrucao = {p[15:0], 16'hC0DE} ^ 32'h5A00_0000;
        branch    = br;
        jump      = jp;
        if (ev) exp_q.push_back({p, instrucao, br, jp});
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; enable = 1'b0; pc = '0; instrucao = '0; branch = 1'b0; jump = 1'b0;
        bp_en = 1'b0; bp_pc = '0; resume = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_total++; if ({cycles, retired, branches, jumps} !== 128'd0)
            $display("FAIL reset_counters: got %0d %0d %0d %0d expected all 0", cycles, retired, branches, jumps); else n_pass++;
        n_total++; if ({v1, h1, o1, c1, r1, b1, j1} !== 11'd0)
            $display("FAIL reset_small: got %b expected 0", {v1, h1, o1, c1, r1, b1, j1}); else n_pass++;
    endtask

    task automatic test_basic();
        logic [65:0] e;
        apply_reset();
        drive(1, 32'h0, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 1);
        drive(1, 32'h4, 0, 0, 1);
        drive(1, 32'h8, 0, 0, 1);
        drive(1, 32'h8, 0, 0, 0);
        drive(0, 32'hC, 0, 0, 1);
        @(negedge clk);
        n_total++; if (cycles !== 32'd5) $display("FAIL basic_cycles: got %0d expected 5", cycles); else n_pass++;
        n_total++; if (retired !== 32'd4) $display("FAIL basic_retired: got %0d expected 4", retired); else n_pass++;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (g > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (out_data !== e) $display("FAIL basic_entry: got %h expected %h", out_data, e); else n_pass++;
            end
        end
        @(negedge clk); out_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL basic_drain: left=%0d out_valid=%b expected 0 and 0", exp_q.size(), out_valid); else n_pass++;
        n_total++; if (cycles !== 32'd5) $display("FAIL basic_cycles_idle: got %0d expected 5", cycles); else n_pass++;
    endtask

    task automatic test_breakpoint();
        logic [65:0] e;
        apply_reset();
        bp_en = 1'b1; bp_pc = 32'h8;
        drive(1, 32'h0, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 1);
        drive(1, 32'h4, 0, 0, 1);
        drive(1, 32'h8, 0, 0, 1);
        @(negedge clk);
        n_total++; if (halt !== 1'b1) $display("FAIL bp_halt: got %b expected 1", halt); else n_pass++;
        drive(1, 32'h8, 0, 0, 0);
        drive(1, 32'h8, 0, 0, 0);
        @(negedge clk);
        n_total++; if (halt !== 1'b1) $display("FAIL bp_halt_hold: got %b expected 1", halt); else n_pass++;
        n_total++; if (retired !== 32'd3) $display("FAIL bp_retired_halted: got %0d expected 3", retired); else n_pass++;
        resume = 1'b1;
        drive(1, 32'h8, 0, 0, 0);
        resume = 1'b0;
        @(negedge clk);
        n_total++; if (halt !== 1'b0) $display("FAIL bp_resume: got %b expected 0", halt); else n_pass++;
        drive(0, 32'hC, 0, 0, 1);
        @(negedge clk);
        n_total++; if (retired !== 32'd4) $display("FAIL bp_retired: got %0d expected 4", retired); else n_pass++;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (g > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (out_data !== e) $display("FAIL bp_entry: got %h expected %h", out_data, e); else n_pass++;
            end
        end
        @(negedge clk); out_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL bp_drain: left=%0d out_valid=%b expected 0 and 0", exp_q.size(), out_valid); else n_pass++;
        bp_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [65:0] e;
        apply_reset();
        drive(1, 32'h200, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive((i == 5) ? 1'b0 : 1'b1, 32'h200 + 32'(4 * i), 0, 0, i < 4);
        @(negedge clk);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
        n_total++; if (retired !== 32'd6) $display("FAIL ovf_retired: got %0d expected 6", retired); else n_pass++;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (g > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (out_data !== e) $display("FAIL ovf_entry: got %h expected %h", out_data, e); else n_pass++;
            end
        end
        @(negedge clk); out_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL ovf_drain: left=%0d out_valid=%b expected 0 and 0", exp_q.size(), out_valid); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [65:0] e;
        apply_reset();
        drive(1, 32'h100, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 32'h100 + 32'(4 * i), 0, 0, 1);
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++; if (out_data !== e) $display("FAIL fpp_head: got %h expected %h", out_data, e); else n_pass++;
        out_ready = 1'b1;
        drive(0, 32'h110, 0, 0, 1);
        out_ready = 1'b0;
        @(negedge clk);
        n_total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow: got %b expected 0", overflow); else n_pass++;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (g > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (out_data !== e) $display("FAIL fpp_entry: got %h expected %h", out_data, e); else n_pass++;
            end
        end
        @(negedge clk); out_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL fpp_drain: left=%0d out_valid=%b expected 0 and 0", exp_q.size(), out_valid); else n_pass++;
    endtask

    task automatic test_counters();
        apply_reset();
        drive(1, 32'h0, 0, 0, 0);
        drive(1, 32'h0, 1, 0, 1);
        drive(1, 32'h4, 1, 0, 1);
        drive(1, 32'h8, 0, 1, 1);
        drive(1, 32'hC, 1, 0, 1);
        drive(0, 32'h10, 0, 1, 1);
        @(negedge clk);
        n_total++; if (branches !== 32'd3) $display("FAIL cnt_branches: got %0d expected 3", branches); else n_pass++;
        n_total++; if (jumps !== 32'd2) $display("FAIL cnt_jumps: got %0d expected 2", jumps); else n_pass++;
        n_total++; if (retired !== 32'd5) $display("FAIL cnt_retired: got %0d expected 5", retired); else n_pass++;
        apply_reset();
        drive(1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive((i == 4) ? 1'b0 : 1'b1, 32'(4 * i), 1, 0, 1);
        @(negedge clk);
        n_total++; if (branches !== 32'd5) $display("FAIL cnt_branches_wide: got %0d expected 5", branches); else n_pass++;
        n_total++; if (b1 !== 2'd3) $display("FAIL cnt_branches_sat: got %0d expected 3", b1); else n_pass++;
        n_total++; if (r1 !== 2'd3 || c1 !== 2'd3)
            $display("FAIL cnt_small_sat: got retired=%0d cycles=%0d expected 3 and 3", r1, c1); else n_pass++;
        n_total++; if (v1 !== 1'b1 || d1 !== exp_q[0])
            $display("FAIL cnt_small_head: got valid=%b data=%h expected 1 and %h", v1, d1, exp_q[0]); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_in_halted();
        logic [65:0] e;
        apply_reset();
        bp_en = 1'b1; bp_pc = 32'h4;
        drive(1, 32'h0, 0, 0, 0);
        drive(1, 32'h0, 1, 0, 1);
        drive(1, 32'h4, 0, 1, 1);
        @(negedge clk);
        n_total++; if (halt !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL rh_pre: got halt=%b valid=%b expected 1 and 1", halt, out_valid); else n_pass++;
        reset = 1'b1; bp_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_total++; if (halt !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL rh_flags: got halt=%b valid=%b ovf=%b expected 0 0 0", halt, out_valid, overflow); else n_pass++;
        n_total++; if ({cycles, retired, branches, jumps} !== 128'd0)
            $display("FAIL rh_counters: got %0d %0d %0d %0d expected all 0", cycles, retired, branches, jumps); else n_pass++;
        drive(1, 32'h4, 0, 0, 0);
        @(negedge clk);
        n_total++; if (cycles !== 32'd0) $display("FAIL rh_idle: got cycles=%0d expected 0", cycles); else n_pass++;
        drive(0, 32'h4, 0, 0, 1);
        @(negedge clk);
        n_total++; if (retired !== 32'd1) $display("FAIL rh_first_event: got %0d expected 1", retired); else n_pass++;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (g > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_total++; if (out_data !== e) $display("FAIL rh_entry: got %h expected %h", out_data, e); else n_pass++;
            end
        end
        @(negedge clk); out_ready = 1'b0;
        n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rh_drain: left=%0d out_valid=%b expected 0 and 0", exp_q.size(), out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_breakpoint();
        test_overflow();
        test_full_push_pop();
        test_counters();
        test_reset_in_halted();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
